instr_byte_loader: RTL and testbench
====================================

# instr_byte_loader

Byte-serial instruction loader and result serializer between the 8-bit pad interface and `single_cycle_datapath`. It assembles four little-endian bytes into a 32-bit instruction and presents it to the core with a valid/ready handshake. When the core accepts an instruction, the block captures the ALU result and streams it back out one byte at a time. Without it, the 32-bit `instr` port cannot be driven from 8 pins.

## Interface
Parameters:
- `XLEN`, 32: instruction and result width; equals `rv32i_defs_InstructionSize`.
- `BYTE_W`, 8: pad byte width. `XLEN % BYTE_W == 0`; `NBYTES = XLEN/BYTE_W`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `byte_in`  in  BYTE_W  incoming instruction byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `instr`  out  XLEN  assembled instruction, to datapath `instr`.
- `instr_valid`  out  1  `instr` is complete and may be executed.
- `instr_ready`  in  1  core executes `instr` this cycle (core step enable).
- `result_in`  in  XLEN  datapath `alu_result`, sampled on instruction accept.
- `result_byte`  out  BYTE_W  current result byte.
- `result_valid`  out  1  `result_byte` is valid.
- `result_ready`  in  1  consumer takes `result_byte`.

## Operation
- Fill FSM has two states, FILL and HOLD. Byte counter `cnt` is 0..NBYTES-1.
- FILL:
  - `byte_ready=1`.
  - On `byte_valid&&byte_ready`: `instr[BYTE_W*cnt +: BYTE_W] <= byte_in`, then `cnt++`.
  - When the byte at `cnt==NBYTES-1` is accepted: `cnt<=0`, go to HOLD.
- HOLD:
  - `byte_ready=0`.
  - `instr_valid = (drain idle)`.
  - Accept occurs on `instr_valid&&instr_ready`. On accept: capture `result_in` into the drain register, set drain index to 0, go to FILL.
  - `instr` holds its value until overwritten by the next FILL bytes.
- Drain (independent counter):
  - Busy while index < NBYTES.
  - `result_valid=busy`.
  - `result_byte = res[BYTE_W*idx +: BYTE_W]` (LSB first) when busy, 0 otherwise.
  - On `result_valid&&result_ready`: `idx++`. After the last byte the drain goes idle.
- The next instruction can fill while the drain is busy. It cannot be accepted until the drain is idle, because `instr_valid` is gated. No result is ever overwritten.
- `instr_ready` while `instr_valid=0` is ignored. `byte_valid` in HOLD is ignored; the byte is not consumed.

## Timing
- Reset: state FILL, `cnt=0`, `instr=0`, drain idle, `res=0`.
  - Outputs after the reset edge: `byte_ready=1`, `instr_valid=0`, `instr=0`, `result_valid=0`, `result_byte=0`.
- Reset mid-operation discards the partial instruction and any pending result bytes.
- Fill latency: the 4th byte is accepted at edge N, and `instr_valid=1` in cycle N+1 (drain idle).
- Accept at edge M:
  - `result_valid=1` with byte 0 in cycle M+1.
  - `instr_valid=0` and `byte_ready=1` in cycle M+1.
- Minimum period with no stalls: NBYTES byte cycles plus 1 accept cycle per instruction.
- The drain sustains 1 byte/cycle when `result_ready` is held high.
- Simultaneous drain-last-byte handshake and `instr_ready` in HOLD: the accept is not taken, since `instr_valid` was 0 that cycle. `instr_valid` rises the next cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `instr_ready` or `result_ready` to any output.

## Structure
- Shared package `rv32i_defs`:
  - Add `ByteSize=8` and `BytesPerWord=InstructionSize/ByteSize`.
  - Add the fill state enum (`LOADER_FILL`, `LOADER_HOLD`).
- One sub-module, `word_serializer`: the drain register, index counter and valid/ready output. It is parameterised by `XLEN`/`BYTE_W` and reusable for an `addr` debug port.

## Test plan
- Reset, then bytes 0x93,0x00,0x50,0x00 with `byte_valid` held high → `instr=0x00500093` and `instr_valid=1` exactly 1 cycle after the 4th byte; `byte_ready=0` in HOLD.
- Accept with `result_in=0x12345678` and `result_ready=1` → `result_byte` sequence 0x78,0x56,0x34,0x12 on 4 consecutive cycles, then `result_valid=0`.
- Hold `result_ready=0` after accept, then fill a second instruction 0x00108113 → `instr_valid` stays 0 until all 4 result bytes have drained, then rises 1 cycle later.
- Gaps in `byte_valid` (bubbles between bytes) → instruction assembled identically; `cnt` does not advance on bubbles.
- Assert `rst` after 2 bytes, then send 0x13,0x00,0x00,0x00 → `instr=0x00000013`, with no residue from the earlier bytes.
- `byte_valid=1` during HOLD with `byte_in=0xFF` → byte not consumed; `instr` unchanged until acceptance.

Source files
------------

// File: rtl/instr_byte_loader_pkg.sv
// Shared RV32I definitions: word/byte geometry and the instruction loader fill-state encoding.
package rv32i_defs;

    localparam int InstructionSize = 32;
    localparam int ByteSize        = 8;
    localparam int BytesPerWord    = InstructionSize / ByteSize;

    typedef enum logic [0:0] {
        LOADER_FILL = 1'b0,
        LOADER_HOLD = 1'b1
    } loader_state_t;

endpackage

// File: rtl/instr_byte_loader_if.sv
// Pad/core/consumer handshake bundle for the instruction byte loader.
// The master drives bytes, core step-enable and the result sink; the slave is the loader.
interface instr_byte_loader_if #(
    parameter int XLEN   = rv32i_defs::InstructionSize,
    parameter int BYTE_W = rv32i_defs::ByteSize
);
    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [XLEN-1:0]   instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [XLEN-1:0]   result_in;
    logic [BYTE_W-1:0] result_byte;
    logic              result_valid;
    logic              result_ready;

    modport master (
        output byte_in, byte_valid, instr_ready, result_in, result_ready,
        input  byte_ready, instr, instr_valid, result_byte, result_valid
    );

    modport slave (
        input  byte_in, byte_valid, instr_ready, result_in, result_ready,
        output byte_ready, instr, instr_valid, result_byte, result_valid
    );
endinterface

// File: rtl/instr_byte_loader_word_serializer.sv
// Word-to-byte drain, LSB first: load captures a word, first byte valid the next cycle, 1 byte/cycle.
// Stalls on dready=0; idle is a registered decode, so load must only be issued while idle.
module word_serializer #(
    parameter int XLEN   = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [XLEN-1:0]   din,
    output logic [BYTE_W-1:0] dout,
    output logic              dvalid,
    input  logic              dready,
    output logic              idle
);
    localparam int NBYTES = XLEN / BYTE_W;
    localparam int IDX_W  = $clog2(NBYTES + 1);

    logic [XLEN-1:0]  res;
    logic [IDX_W-1:0] idx;
    logic             busy;

    // idx == NBYTES encodes "nothing left to send"
    assign busy   = (idx < IDX_W'(NBYTES));
    assign idle   = ~busy;
    assign dvalid = busy;
    assign dout   = busy ? BYTE_W'(res >> (BYTE_W * idx)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
            idx <= IDX_W'(NBYTES);
        end else if (load) begin
            res <= din;
            idx <= '0;
        end else if (busy && dready) begin
            idx <= idx + IDX_W'(1);
        end
    end
endmodule

// File: rtl/instr_byte_loader.sv
// Assembles NBYTES little-endian pad bytes into an instruction; instr_valid one cycle after the last byte.
// Accept is held off while the previous result drains; bytes arriving in HOLD are not consumed.
module instr_byte_loader
    import rv32i_defs::*;
#(
    parameter int XLEN   = InstructionSize,
    parameter int BYTE_W = ByteSize
) (
    input  logic                clk,
    input  logic                rst,
    instr_byte_loader_if.slave  bus
);
    localparam int NBYTES = XLEN / BYTE_W;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    loader_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  instr_q;
    logic             drain_idle;
    logic             last_byte;
    logic             byte_fire;
    logic             accept;

    assign last_byte = (cnt == CNT_W'(NBYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= LOADER_FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.byte_ready  = 1'b0;
        bus.instr_valid = 1'b0;
        case (state)
            LOADER_FILL: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid && last_byte) state_nxt = LOADER_HOLD;
            end
            LOADER_HOLD: begin
                // Gating on drain_idle guarantees a pending result is never overwritten
                bus.instr_valid = drain_idle;
                if (drain_idle && bus.instr_ready) state_nxt = LOADER_FILL;
            end
            default: state_nxt = LOADER_FILL;
        endcase
    end

    assign byte_fire = bus.byte_valid && bus.byte_ready;
    assign accept    = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            instr_q <= '0;
        end else if (byte_fire) begin
            instr_q[BYTE_W*cnt +: BYTE_W] <= bus.byte_in;
            cnt <= last_byte ? '0 : cnt + CNT_W'(1);
        end
    end

    assign bus.instr = instr_q;

    word_serializer #(
        .XLEN   (XLEN),
        .BYTE_W (BYTE_W)
    ) u_drain (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .din    (bus.result_in),
        .dout   (bus.result_byte),
        .dvalid (bus.result_valid),
        .dready (bus.result_ready),
        .idle   (drain_idle)
    );
endmodule

// File: tb/tb_instr_byte_loader.sv
// Directed bench for instr_byte_loader with a result-byte scoreboard fed on every instruction accept.
module tb_instr_byte_loader;
    import rv32i_defs::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_byte_loader_if #(.XLEN(32), .BYTE_W(8)) bus ();

    instr_byte_loader #(.XLEN(32), .BYTE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs are set right after a falling edge; handshakes are observed mid-low-phase
    // and then take effect at the coming rising edge.
    task automatic tick();
        #1;
        if (!rst) begin
            if (bus.result_valid && bus.result_ready) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_result_byte observed=0x%02h expected=none", bus.result_byte);
                end
                if (sb.size() > 0) chk("result_byte", {24'h0, bus.result_byte}, {24'h0, sb.pop_front()});
            end
            if (bus.instr_valid && bus.instr_ready) begin
                for (int i = 0; i < 4; i++) sb.push_back(bus.result_in[8*i +: 8]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && n < 20) begin
            tick();
            n++;
        end
        chk("byte_ready_timeout", {31'h0, (n < 20)}, 32'h1);
        tick();
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        bus.result_ready = 1'b1;
        while (sb.size() > 0 && n < 12) begin
            tick();
            n++;
        end
        chk("drain_complete", sb.size(), 0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.byte_in      = '0;
        bus.byte_valid   = 1'b0;
        bus.instr_ready  = 1'b0;
        bus.result_in    = '0;
        bus.result_ready = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_byte_ready",   bus.byte_ready,   1);
        chk("rst_instr_valid",  bus.instr_valid,  0);
        chk("rst_instr",        bus.instr,        32'h0);
        chk("rst_result_valid", bus.result_valid, 0);
        chk("rst_result_byte",  bus.result_byte,  0);

        // Back-to-back fill
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50);
        chk("fill3_instr_valid", bus.instr_valid, 0);
        send_byte(8'h00);
        bus.byte_valid = 1'b0;
        chk("fill_instr_valid", bus.instr_valid, 1);
        chk("fill_instr",       bus.instr,       32'h00500093);
        chk("hold_byte_ready",  bus.byte_ready,  0);

        // Accept and full-rate drain
        bus.result_in    = 32'h12345678;
        bus.result_ready = 1'b1;
        bus.instr_ready  = 1'b1;
        tick();
        bus.instr_ready  = 1'b0;
        chk("acc_result_valid", bus.result_valid, 1);
        chk("acc_result_byte0", bus.result_byte,  32'h78);
        chk("acc_instr_valid",  bus.instr_valid,  0);
        chk("acc_byte_ready",   bus.byte_ready,   1);
        repeat (4) tick();
        chk("drain4_empty",        sb.size(),        0);
        chk("drain_done_valid",    bus.result_valid, 0);
        chk("drain_done_byte",     bus.result_byte,  0);

        // Fill with bubbles
        send_byte(8'h13); bus.byte_valid = 1'b0; tick(); tick();
        send_byte(8'h81); bus.byte_valid = 1'b0; tick();
        send_byte(8'h10); bus.byte_valid = 1'b0; tick(); tick(); tick();
        chk("bubble_instr_valid_early", bus.instr_valid, 0);
        send_byte(8'h00); bus.byte_valid = 1'b0;
        chk("bubble_instr_valid", bus.instr_valid, 1);
        chk("bubble_instr",       bus.instr,       32'h00108113);

        // Accept with the consumer stalled, then fill the next instruction behind it
        bus.result_ready = 1'b0;
        bus.result_in    = 32'hCAFEF00D;
        bus.instr_ready  = 1'b1;
        tick();
        bus.result_in    = 32'h0BADF00D;
        send_byte(8'h93); send_byte(8'h81); send_byte(8'h20); send_byte(8'h00);
        chk("gated_instr_valid",  bus.instr_valid,  0);
        chk("gated_instr",        bus.instr,        32'h00208193);
        chk("stall_result_valid", bus.result_valid, 1);
        chk("stall_result_byte",  bus.result_byte,  32'h0D);

        // Bytes offered in HOLD are not consumed
        bus.byte_in = 8'hFF;
        repeat (3) tick();
        chk("holdff_byte_ready",  bus.byte_ready,  0);
        chk("holdff_instr",       bus.instr,       32'h00208193);
        chk("holdff_instr_valid", bus.instr_valid, 0);
        bus.byte_valid = 1'b0;

        // Last drain byte coincides with instr_ready: accept waits one cycle
        bus.result_ready = 1'b1;
        repeat (4) tick();
        chk("postdrain_empty",        sb.size(),        0);
        chk("postdrain_instr_valid",  bus.instr_valid,  1);
        chk("postdrain_result_valid", bus.result_valid, 0);
        tick();
        bus.instr_ready  = 1'b0;
        bus.result_ready = 1'b0;
        chk("acc2_instr_valid",  bus.instr_valid,  0);
        chk("acc2_result_valid", bus.result_valid, 1);
        chk("acc2_result_byte",  bus.result_byte,  32'h0D);

        // Reset mid-fill with result bytes still pending
        send_byte(8'hAA); send_byte(8'hBB);
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("mid_rst_instr",        bus.instr,        32'h0);
        chk("mid_rst_result_valid", bus.result_valid, 0);
        chk("mid_rst_result_byte",  bus.result_byte,  0);
        chk("mid_rst_byte_ready",   bus.byte_ready,   1);
        chk("mid_rst_instr_valid",  bus.instr_valid,  0);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        bus.byte_valid = 1'b0;
        chk("post_rst_instr",       bus.instr,       32'h00000013);
        chk("post_rst_instr_valid", bus.instr_valid, 1);

        bus.result_in    = 32'hA5A50001;
        bus.result_ready = 1'b1;
        bus.instr_ready  = 1'b1;
        tick();
        bus.instr_ready  = 1'b0;
        drain_all();
        chk("final_result_valid", bus.result_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
